// File: rtl/hex_display_pkg.sv
// Shared types, constants and helpers for the hex display unit.
// Holds the FSM state encoding, segment constants, the 0-F glyph table
// and the double-dabble digit adjust step.
package hex_display_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BCD_W  = 40;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0]  SEG_DASH  = 7'h3F;
    localparam logic [DATA_W-1:0] DEC_LIMIT = 32'd100_000_000;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for value 0.
    localparam logic [15:0][SEG_W-1:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < 10; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_display_unit_if.sv
// CPU-side write interface of the hex display unit.
// wr_en/wr_data/dec_mode : write strobe, value and mode (master -> slave)
// busy                   : conversion or pending write outstanding (slave -> master)
interface hex_display_unit_if;
    import hex_display_pkg::*;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              dec_mode;
    logic              busy;

    modport master (output wr_en, output wr_data, output dec_mode, input busy);
    modport slave  (input wr_en, input wr_data, input dec_mode, output busy);

endinterface

// File: rtl/hex_display_unit_seg7_decode.sv
// Combinational seven-segment decoder.
// value : 4-bit digit value
// blank : force all segments off
// seg_c : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0]       value,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            seg_c = GLYPH[value];
        end
    end

endmodule

// File: rtl/hex_display_unit.sv
// Eight-digit seven-segment display driver for the CPU display CSR.
// Hex mode shows raw nibbles; decimal mode converts with a 32-cycle
// double-dabble, with optional leading-zero blanking and a dash pattern
// for values of 100_000_000 and above. One-deep pending write buffer.
// clk, rst_n  : clock, asynchronous active-low reset
// bus (slave) : wr_en, wr_data, dec_mode in; busy out
// HEX0..HEX7  : registered active-low segments, HEX0 least significant
module hex_display_unit
    import hex_display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    hex_display_unit_if.slave bus,
    output logic [SEG_W-1:0] HEX0,
    output logic [SEG_W-1:0] HEX1,
    output logic [SEG_W-1:0] HEX2,
    output logic [SEG_W-1:0] HEX3,
    output logic [SEG_W-1:0] HEX4,
    output logic [SEG_W-1:0] HEX5,
    output logic [SEG_W-1:0] HEX6,
    output logic [SEG_W-1:0] HEX7
);

    localparam int unsigned SH_W = BCD_W + DATA_W;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [DATA_W-1:0]              bin;
    logic [BCD_W-1:0]               bcd;
    logic                           cur_dec;
    logic                           cur_ovf;
    logic                           pend_valid;
    logic [DATA_W-1:0]              pend_data;
    logic                           pend_dec;
    logic                           busy_q;
    logic [DIGITS-1:0][SEG_W-1:0]   hex_q;

    logic [DATA_W-1:0]              ld_data;
    logic                           ld_dec;
    logic                           busy_nxt;
    logic [BCD_W-1:0]               adj;
    logic [SH_W-1:0]                sh;
    logic [DATA_W-1:0]              digits;
    logic [DIGITS-1:0]              blank;
    logic [DIGITS-1:0][SEG_W-1:0]   seg_raw;
    logic [DIGITS-1:0][SEG_W-1:0]   seg_new;

    // Next value to load: a fresh write always beats the pending slot.
    always_comb begin
        ld_data = bus.wr_en ? bus.wr_data  : pend_data;
        ld_dec  = bus.wr_en ? bus.dec_mode : pend_dec;
    end

    // busy for the next cycle: work in flight or about to start.
    always_comb begin
        busy_nxt = 1'b0;
        case (state)
            IDLE:    busy_nxt = bus.wr_en;
            SHIFT:   busy_nxt = 1'b1;
            COMMIT:  busy_nxt = bus.wr_en | pend_valid;
            default: busy_nxt = 1'b0;
        endcase
    end

    // One double-dabble step on the combined {bcd, bin} register.
    always_comb begin
        adj = dd_adjust(bcd);
        sh  = {adj, bin} << 1;
    end

    // After 32 shifts bin is empty in decimal mode, bcd is empty in hex mode.
    assign digits = cur_dec ? bcd[DATA_W-1:0] : bin;

    // Blank digits above the most significant nonzero one; HEX0 always shows.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen     = seen | (digits[4*i +: 4] != 4'd0);
            blank[i] = BLANK_LZ && cur_dec && !seen && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .value (digits[4*g +: 4]),
            .blank (blank[g]),
            .seg_c (seg_raw[g])
        );
        assign seg_new[g] = cur_ovf ? SEG_DASH : seg_raw[g];
    end

    // Control FSM with conversion datapath, pending slot and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bin        <= '0;
            bcd        <= '0;
            cur_dec    <= 1'b0;
            cur_ovf    <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_dec   <= 1'b0;
            busy_q     <= 1'b0;
            hex_q      <= {DIGITS{SEG_BLANK}};
        end else begin
            busy_q <= busy_nxt;
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        bin     <= ld_data;
                        bcd     <= '0;
                        cnt     <= '0;
                        cur_dec <= ld_dec;
                        cur_ovf <= ld_dec && (ld_data >= DEC_LIMIT);
                        state   <= ld_dec ? SHIFT : COMMIT;
                    end
                end
                SHIFT: begin
                    bcd <= sh[SH_W-1:DATA_W];
                    bin <= sh[DATA_W-1:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= COMMIT;
                    end
                    if (bus.wr_en) begin
                        pend_valid <= 1'b1;
                        pend_data  <= bus.wr_data;
                        pend_dec   <= bus.dec_mode;
                    end
                end
                COMMIT: begin
                    hex_q      <= seg_new;
                    pend_valid <= 1'b0;
                    if (bus.wr_en || pend_valid) begin
                        bin     <= ld_data;
                        bcd     <= '0;
                        cnt     <= '0;
                        cur_dec <= ld_dec;
                        cur_ovf <= ld_dec && (ld_data >= DEC_LIMIT);
                        state   <= ld_dec ? SHIFT : COMMIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_display_unit.sv
// Self-checking bench for hex_display_unit: a table of single writes
// followed by hand-timed latency, pending-buffer and reset sequences.
module tb_hex_display_unit;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [55:0] disp;

    hex_display_unit_if bus();

    hex_display_unit #(.BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2),
        .HEX3  (HEX3),
        .HEX4  (HEX4),
        .HEX5  (HEX5),
        .HEX6  (HEX6),
        .HEX7  (HEX7)
    );

    always #5 clk = ~clk;

    assign disp = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    typedef struct {
        string       name;
        bit          dec;
        logic [31:0] data;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle write; returns in the cycle after the strobe.
    task automatic wr(input bit dec, input logic [31:0] data);
        bus.wr_en    = 1'b1;
        bus.dec_mode = dec;
        bus.wr_data  = data;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_timeout: busy still %b after 80 cycles, required 0", name, bus.busy);
        end
    endtask

    initial begin
        logic [55:0] prev;
        bit          agg;

        vecs[0] = '{"hex_12345678", 1'b0, 32'h1234_5678,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[1] = '{"dec_123456", 1'b1, 32'd123456,
                    {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[2] = '{"dec_100000000", 1'b1, 32'd100_000_000, {8{7'h3F}}};
        vecs[3] = '{"dec_99999999", 1'b1, 32'd99_999_999, {8{7'h10}}};
        vecs[4] = '{"dec_zero", 1'b1, 32'd0, {{7{7'h7F}}, 7'h40}};
        vecs[5] = '{"hex_fedcba90", 1'b0, 32'hFEDC_BA90,
                    {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h40}};
        vecs[6] = '{"hex_zero", 1'b0, 32'h0, {8{7'h40}}};
        vecs[7] = '{"dec_max_u32", 1'b1, 32'hFFFF_FFFF, {8{7'h3F}}};
        vecs[8] = '{"dec_10203", 1'b1, 32'd10203,
                    {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30}};

        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.dec_mode = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_disp", disp, ALL_BLANK);
        check("reset_busy", 56'(bus.busy), 56'(1'b0));
        rst_n = 1'b1;
        tick();

        // Table: one write each, wait for idle, compare whole display
        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].dec, vecs[i].data);
            wait_idle(vecs[i].name);
            check(vecs[i].name, disp, vecs[i].exp);
        end
        prev = vecs[8].exp;

        // Hex latency: busy for exactly one cycle, display at cycle 2
        wr(1'b0, 32'h1234_5678);
        check("hexlat_c1_busy", 56'(bus.busy), 56'(1'b1));
        check("hexlat_c1_disp", disp, prev);
        tick();
        check("hexlat_c2_busy", 56'(bus.busy), 56'(1'b0));
        check("hexlat_c2_disp", disp, vecs[0].exp);
        prev = vecs[0].exp;

        // Decimal latency: busy over cycles 1-33, display at cycle 34
        wr(1'b1, 32'd123456);
        check("declat_c1_busy", 56'(bus.busy), 56'(1'b1));
        agg = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (bus.busy !== 1'b1 || disp !== prev) agg = 1'b0;
            tick();
        end
        check("declat_hold_c1_33", 56'(agg), 56'(1'b1));
        check("declat_c34_disp", disp, vecs[1].exp);
        check("declat_c34_busy", 56'(bus.busy), 56'(1'b0));
        prev = vecs[1].exp;

        // Pending: decimal 5, hex A at cycle 3 (dropped), hex B at cycle 10
        wr(1'b1, 32'd5);
        tick();
        tick();
        wr(1'b0, 32'hA);
        repeat (6) tick();
        wr(1'b0, 32'hB);
        repeat (22) tick();
        check("pend_c33_disp", disp, prev);
        tick();
        check("pend_c34_disp", disp, {{7{7'h7F}}, 7'h12});
        check("pend_c34_busy", 56'(bus.busy), 56'(1'b1));
        tick();
        check("pend_c35_disp", disp, {{7{7'h40}}, 7'h03});
        check("pend_c35_busy", 56'(bus.busy), 56'(1'b0));

        // Reset mid-SHIFT: decimal 42, reset over cycles 15-20
        wr(1'b1, 32'd42);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_disp", disp, ALL_BLANK);
        check("rst_mid_busy", 56'(bus.busy), 56'(1'b0));
        repeat (5) tick();
        rst_n = 1'b1;
        agg = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.busy !== 1'b0 || disp !== ALL_BLANK) agg = 1'b0;
        end
        check("rst_no_commit", 56'(agg), 56'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
